// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and sizing helpers for the shared register arbiter.
package shared_reg_arbiter_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    COOLDOWN = 1'b1
  } state_t;

  // Index/counter width: ceil(log2(n)), never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after i_ptr wins.
module rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);

  logic          w_found;
  logic [IW-1:0] w_pos;

  // Scan ptr, ptr+1, ... modulo N and latch onto the first active request.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_pos = IW'((32'(i_ptr) + k) % N);
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter in front of one shared storage register, with post-write cooldown.
// Optional macro SHARED_REG_ARBITER_PRIO0_EN gives requester 0 absolute priority.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(NUM_REQ)-1:0] q_owner,
  output logic                       q_valid,
  output logic                       busy
);

  localparam int unsigned    IW       = clog2_min1(NUM_REQ);
  localparam int unsigned    CW       = clog2_min1(GAP_CYCLES + 32'd1);
  localparam logic [CW-1:0]  CNT_INIT = (GAP_CYCLES > 32'd0) ? CW'(GAP_CYCLES - 32'd1) : '0;
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_REQ - 32'd1);

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [IW-1:0]        r_ptr, w_ptr_nxt;
  logic [NUM_REQ-1:0]   w_rr_grant, w_grant;
  logic [IW-1:0]        w_rr_idx, w_idx;
  logic                 w_keep_ptr, w_idle, w_hs;
  logic [WIDTH-1:0]     r_q;
  logic [IW-1:0]        r_owner;
  logic                 r_q_valid;

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx)
  );

  // Winner selection; the priority build overrides round-robin for requester 0.
  always_comb begin
    w_grant    = w_rr_grant;
    w_idx      = w_rr_idx;
    w_keep_ptr = 1'b0;
`ifdef SHARED_REG_ARBITER_PRIO0_EN
    if (req_valid[0]) begin
      w_grant    = {{(NUM_REQ-1){1'b0}}, 1'b1};
      w_idx      = '0;
      w_keep_ptr = 1'b1;
    end else begin
      w_keep_ptr = 1'b0;
    end
`endif
  end

  assign w_idle    = (r_state == IDLE);
  assign req_ready = (w_idle && !rst) ? w_grant : '0;
  assign w_hs      = |req_ready;
  assign w_ptr_nxt = (w_idx == LAST_IDX) ? '0 : w_idx + IW'(1);

  // Next state and cooldown count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_hs && (GAP_CYCLES > 32'd0)) begin
          w_state_nxt = COOLDOWN;
          w_cnt_nxt   = CNT_INIT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      COOLDOWN: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Shared register, owner and pointer update on an accepted handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= '0;
      r_owner   <= '0;
      r_q_valid <= 1'b0;
      r_ptr     <= '0;
    end else if (w_hs) begin
      r_q       <= req_data[w_idx*WIDTH +: WIDTH];
      r_owner   <= w_idx;
      r_q_valid <= 1'b1;
      if (!w_keep_ptr) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  assign q       = r_q;
  assign q_owner = r_owner;
  assign q_valid = r_q_valid;
  assign busy    = !w_idle;

endmodule
